// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling on a cycle counter.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx #(
    parameter int unsigned cycles_per_bit = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned CycW = $clog2(cycles_per_bit);
    localparam logic [CycW-1:0] HalfLast = CycW'(cycles_per_bit / 2 - 1);
    localparam logic [CycW-1:0] BitLast  = CycW'(cycles_per_bit - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            sync;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cyc_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], ser_rx};
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + CycW'(1);
        bitn_d  = bitn_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (!sync) state_d = StStart;
            end
            StStart: begin
                // Mid start bit: a high line here was only a glitch.
                if (cyc_q == HalfLast) begin
                    cyc_d   = '0;
                    bitn_d  = '0;
                    state_d = sync ? StIdle : StData;
                end
            end
            StData: begin
                if (cyc_q == BitLast) begin
                    cyc_d   = '0;
                    shift_d = {sync, shift_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cyc_q == BitLast) begin
                    cyc_d   = '0;
                    par_d   = sync;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Leave mid stop bit so a following start edge is never missed.
                if (cyc_q == BitLast) begin
                    cyc_d   = '0;
                    state_d = StIdle;
                    if (!sync) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif
    assign busy       = (state_q != StIdle);

endmodule
